// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Contents:
//   - MDU operation codes (the same codes the decoder emits as MDU_op)
//   - FSM state encoding
//   - counter width and helpers that classify an op code
package mdu_unit_pkg;

  // Six bits covers the full 1..63 latency range for both mult and div.
  localparam int CTR_W = 6;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic isMulDiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic isDiv(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Signed/unsigned divider with a start/done handshake.
// The result is computed combinationally from the operands presented with
// i_start and held in registers; done stays high until reset so the FSM can
// treat it as "result available". Keeping the handshake lets this become an
// iterative divider later without touching the controlling FSM.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   i_start        - capture the division of i_dividend by i_divisor
//   i_signed       - 1 for DIV (signed), 0 for DIVU
//   i_dividend     - dividend (rs)
//   i_divisor      - divisor (rt)
//   o_done         - a captured result is available
//   o_quot, o_rem  - quotient (toward zero) and remainder (sign of dividend)
//   o_divByZero    - the captured divisor was zero; result must be discarded
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_divByZero
);

  logic             w_negDividend;
  logic             w_negDivisor;
  logic [WIDTH-1:0] w_absDividend;
  logic [WIDTH-1:0] w_absDivisor;
  logic [WIDTH-1:0] w_absQuot;
  logic [WIDTH-1:0] w_absRem;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic             w_zero;

  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_divByZero;

  // Divide magnitudes and reapply signs. This also handles min_int / -1:
  // |min_int| is representable unsigned, the quotient negates back to
  // min_int and the remainder is zero.
  always_comb begin
    w_negDividend = i_signed & i_dividend[WIDTH-1];
    w_negDivisor  = i_signed & i_divisor[WIDTH-1];
    w_absDividend = w_negDividend ? (~i_dividend + 1'b1) : i_dividend;
    w_absDivisor  = w_negDivisor  ? (~i_divisor  + 1'b1) : i_divisor;
    w_zero        = (i_divisor == '0);
    w_absQuot     = '0;
    w_absRem      = '0;
    if (!w_zero) begin
      w_absQuot = w_absDividend / w_absDivisor;
      w_absRem  = w_absDividend % w_absDivisor;
    end
    w_quot = (w_negDividend ^ w_negDivisor) ? (~w_absQuot + 1'b1) : w_absQuot;
    w_rem  = w_negDividend ? (~w_absRem + 1'b1) : w_absRem;
  end

  // Capture the result on start and hold it until the FSM commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_divByZero <= 1'b0;
    end else if (i_start) begin
      r_done      <= 1'b1;
      r_quot      <= w_quot;
      r_rem       <= w_rem;
      r_divByZero <= w_zero;
    end
  end

  assign o_done      = r_done;
  assign o_quot      = r_quot;
  assign o_rem       = r_rem;
  assign o_divByZero = r_divByZero;

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// A start pulse with a mult/div op latches the operands and holds busy for
// MULT_CYCLES or DIV_CYCLES cycles, after which HI/LO are written. MTHI/MTLO
// write HI/LO at the next edge without going busy. Cancel aborts an
// in-flight op and leaves HI/LO untouched.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   start      - launch the op on 'op' this cycle
//   op         - MDU operation code (mdu_op_e)
//   A, B       - forwarded rs / rt values
//   cancel     - abort the in-flight operation
//   busy       - an operation is in flight
//   stall_req  - busy, or a mult/div is being launched this cycle
//   HI, LO     - architectural HI/LO registers
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e         r_state;
  mdu_state_e         w_nextState;
  logic [CTR_W-1:0]   r_ctr;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_launch;
  logic               w_moveHi;
  logic               w_moveLo;
  logic               w_commit;
  logic [2*WIDTH-1:0] w_prodS;
  logic [2*WIDTH-1:0] w_prodU;
  logic               w_divDone;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_divByZero;

  // Starts are only honoured in IDLE, so a start while busy is dropped and
  // a start with cancel in IDLE simply launches.
  assign w_launch = (r_state == ST_IDLE) && start && isMulDiv(op);
  assign w_moveHi = (r_state == ST_IDLE) && start && (op == MDU_MTHI);
  assign w_moveLo = (r_state == ST_IDLE) && start && (op == MDU_MTLO);

  // Products come from the latched operands so later A/B changes are ignored.
  assign w_prodS = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) *
                   $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_prodU = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_divCore (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_launch && isDiv(op)),
    .i_signed   (op == MDU_DIV),
    .i_dividend (A),
    .i_divisor  (B),
    .o_done     (w_divDone),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_divByZero(w_divByZero)
  );

  // Next-state logic. Cancel takes priority over the final-cycle commit.
  always_comb begin
    w_nextState = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        if (cancel) begin
          w_nextState = ST_IDLE;
        end else if (r_ctr == CTR_W'(1)) begin
          w_nextState = ST_IDLE;
          w_commit    = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State, counter, operand latches and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ctr   <= '0;
      r_op    <= MDU_NONE;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_launch) begin
        r_op  <= op;
        r_a   <= A;
        r_b   <= B;
        r_ctr <= isDiv(op) ? CTR_W'(DIV_CYCLES) : CTR_W'(MULT_CYCLES);
      end else if (r_state == ST_RUN) begin
        r_ctr <= cancel ? '0 : r_ctr - 1'b1;
      end
      if (w_commit) begin
        case (r_op)
          MDU_MULT:  {r_hi, r_lo} <= w_prodS;
          MDU_MULTU: {r_hi, r_lo} <= w_prodU;
          MDU_DIV, MDU_DIVU: begin
            // A zero divisor lets the latency elapse but writes nothing.
            if (w_divDone && !w_divByZero) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end
          default: ;
        endcase
      end
      if (w_moveHi) r_hi <= A;
      if (w_moveLo) r_lo <= A;
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign stall_req = busy | (start & isMulDiv(op));
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed testbench for mdu_unit with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;

  int checkCount = 0;
  int errorCount = 0;

  mdu_unit #(
    .WIDTH(32),
    .MULT_CYCLES(MC),
    .DIV_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .cancel   (cancel),
    .busy     (busy),
    .stall_req(stall_req),
    .HI       (HI),
    .LO       (LO)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let them settle.
  task automatic applyStimulus(input logic s, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic c);
    @(negedge clk);
    start  = s;
    op     = o;
    A      = a;
    B      = b;
    cancel = c;
    #1;
  endtask

  // Launch a mult/div op and follow it for n busy cycles.
  // cancelAt: busy cycle index (0-based) on which cancel is asserted, -1 none.
  // restartAt: busy cycle index on which a second MULT start is pulsed, -1 none.
  // Operands on A/B are scrambled during the run to prove they were latched.
  task automatic runOp(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int n, input int cancelAt, input int restartAt,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    logic expBusy;
    applyStimulus(1'b1, o, a, b, 1'b0);
    checkOutput({tag, " stall at start"}, 32'(stall_req), 32'd1);
    checkOutput({tag, " idle at start"}, 32'(busy), 32'd0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(i == restartAt, MDU_MULT, 32'h0000_1000, 32'h0000_1000,
                    i == cancelAt);
      expBusy = (cancelAt < 0) || (i <= cancelAt);
      checkOutput({tag, " busy"}, 32'(busy), 32'(expBusy));
      checkOutput({tag, " stall"}, 32'(stall_req), 32'(expBusy | (i == restartAt)));
    end
    applyStimulus(1'b0, MDU_NONE, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    checkOutput({tag, " busy done"}, 32'(busy), 32'd0);
    checkOutput({tag, " HI"}, HI, expHi);
    checkOutput({tag, " LO"}, LO, expLo);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = MDU_NONE;
    A      = '0;
    B      = '0;
    cancel = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    checkOutput("reset HI", HI, 32'h0);
    checkOutput("reset LO", LO, 32'h0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset stall", 32'(stall_req), 32'd0);

    // Multiply: -2 * 3 signed and unsigned.
    runOp("MULT", MDU_MULT, 32'hFFFF_FFFE, 32'd3, MC, -1, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("MULTU", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, MC, -1, -1, 32'h0000_0002, 32'hFFFF_FFFA);

    // Divide: -7/2 signed, 7/2 unsigned, min_int / -1.
    runOp("DIV", MDU_DIV, 32'hFFFF_FFF9, 32'd2, DC, -1, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("DIVU", MDU_DIVU, 32'd7, 32'd2, DC, -1, -1, 32'd1, 32'd3);
    runOp("DIV ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, -1, -1, 32'h0, 32'h8000_0000);

    // MTHI/MTLO back to back: no busy, no stall, visible one edge later.
    applyStimulus(1'b1, MDU_MTHI, 32'h0000_1234, 32'h0, 1'b0);
    checkOutput("MTHI stall", 32'(stall_req), 32'd0);
    applyStimulus(1'b1, MDU_MTLO, 32'h0000_5678, 32'h0, 1'b0);
    checkOutput("MTHI HI", HI, 32'h0000_1234);
    checkOutput("MTLO stall", 32'(stall_req), 32'd0);
    checkOutput("MTHI busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("MTLO LO", LO, 32'h0000_5678);
    checkOutput("MTLO busy", 32'(busy), 32'd0);

    // Divide by zero keeps prior HI/LO.
    applyStimulus(1'b1, MDU_MTHI, 32'h11, 32'h0, 1'b0);
    applyStimulus(1'b1, MDU_MTLO, 32'h22, 32'h0, 1'b0);
    runOp("DIV by 0", MDU_DIV, 32'd100, 32'd0, DC, -1, -1, 32'h11, 32'h22);

    // Cancel on the 4th busy cycle; remaining cycles confirm no late commit.
    runOp("DIV cancel", MDU_DIV, 32'd100, 32'd7, DC, 3, -1, 32'h11, 32'h22);

    // Cancel coinciding with the commit edge: no write.
    runOp("cancel at commit", MDU_MULT, 32'd2, 32'd3, MC, MC - 1, -1, 32'h11, 32'h22);

    // Start with cancel in IDLE launches normally.
    applyStimulus(1'b1, MDU_MULT, 32'd6, 32'd7, 1'b1);
    applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("start+cancel idle busy", 32'(busy), 32'd1);
    repeat (MC - 1) applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("start+cancel idle busy end", 32'(busy), 32'd0);
    checkOutput("start+cancel idle LO", LO, 32'd42);
    checkOutput("start+cancel idle HI", HI, 32'd0);

    // Second start while busy is ignored; first result commits on time.
    runOp("restart busy", MDU_MULTU, 32'd5, 32'd5, MC, -1, 1, 32'd0, 32'd25);

    // Unlisted op and MDU_NONE with start do nothing.
    applyStimulus(1'b1, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("op7 stall", 32'(stall_req), 32'd0);
    applyStimulus(1'b1, MDU_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("op7 busy", 32'(busy), 32'd0);
    checkOutput("op7 HI", HI, 32'd0);
    applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("none LO", LO, 32'd25);

    // Reset mid-MULT clears everything and discards the result.
    applyStimulus(1'b1, MDU_MTHI, 32'hAA, 32'h0, 1'b0);
    applyStimulus(1'b1, MDU_MULT, 32'd3, 32'd4, 1'b0);
    applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset HI", HI, 32'd0);
    checkOutput("mid reset LO", LO, 32'd0);
    repeat (MC) applyStimulus(1'b0, MDU_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("post reset LO", LO, 32'd0);
    checkOutput("post reset busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
